mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/mem_resp_ram.sv | 27 ++
 rtl/mem_resp.sv | 123 ++++++++++++
 tb/tb_mem_resp.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types, widths and helpers for the mem_resp slave.
package mem_resp_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned LAT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // A request is in range when no address bit at or above the word-index width is set.
    function automatic logic in_range(input logic [ADDR_W-1:0] a, input int unsigned aw);
        return (a >> aw) == '0;
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port storage: synchronous write, combinational read of the addressed word.
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Word write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/mem_resp.sv
// Fixed-latency memory slave: accepts one request, responds with a one-cycle rdy pulse
// LAT cycles later, then enforces a one-cycle gap before the next acceptance.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned LAT = 4,
    parameter int unsigned AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              req,
    input  logic              wr,
    output logic              rdy,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              oor
);

    localparam logic [LAT_W-1:0] LAT_M1    = LAT_W'(LAT - 1);
    localparam logic             MULTI_CYC = (LAT > 1);

    state_t             r_state;
    state_t             w_next;
    logic [LAT_W-1:0]   r_cnt;
    logic               r_wr;
    logic [DATA_W-1:0]  r_hold;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_rdy;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic               r_oor;

    logic               w_accept;
    logic               w_inr;
    logic               w_we;
    logic [DATA_W-1:0]  w_ram_rdata;
    logic [DATA_W-1:0]  w_acc_data;

    assign w_accept   = (r_state == ST_IDLE) && req;
    assign w_inr      = in_range(addr, AW);
    assign w_we       = w_accept && wr && w_inr;
    // Response data is fixed at acceptance: zero for writes and out-of-range reads.
    assign w_acc_data = (!wr && w_inr) ? w_ram_rdata : '0;

    mem_resp_ram #(.AW(AW)) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_addr    (addr[AW-1:0]),
        .i_wdata   (wdata),
        .o_rdata_c (w_ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; req only matters in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req) w_next = MULTI_CYC ? ST_BUSY : ST_RESP;
            ST_BUSY: if (r_cnt == LAT_W'(1)) w_next = ST_RESP;
            ST_RESP: w_next = ST_GAP;
            ST_GAP:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Transaction capture, latency countdown and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_hold  <= '0;
            r_rdata <= '0;
            r_rdy   <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            r_rdy   <= (w_next == ST_RESP);
            // With LAT=1 the response follows acceptance directly, so bypass the hold register.
            r_rdata <= (w_next == ST_RESP) ? ((r_state == ST_IDLE) ? w_acc_data : r_hold) : '0;
            if (w_accept) begin
                r_cnt  <= LAT_M1;
                r_wr   <= wr;
                r_hold <= w_acc_data;
                if (!w_inr) begin
                    r_oor <= 1'b1;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - LAT_W'(1);
            end
        end
    end

    // Completion counters advance on the response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (r_state == ST_RESP) begin
            if (r_wr) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end else begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    assign rdata  = r_rdata;
    assign rdy    = r_rdy;
    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
    assign oor    = r_oor;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: a LAT=4 instance and a LAT=1 instance with a scoreboard queue each.
module tb_mem_resp;
    import mem_resp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req4, wr4, rdy4, oor4;
    logic [63:0] addr4, wdata4, rdata4;
    logic [31:0] rd_cnt4, wr_cnt4;
    logic        req1, wr1, rdy1, oor1;
    logic [63:0] addr1, wdata1, rdata1;
    logic [31:0] rd_cnt1, wr_cnt1;

    mem_resp #(.LAT(4), .AW(10)) u_dut4 (
        .clk(clk), .reset(rst_n), .addr(addr4), .wdata(wdata4), .rdata(rdata4),
        .req(req4), .wr(wr4), .rdy(rdy4), .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4), .oor(oor4)
    );

    mem_resp #(.LAT(1), .AW(10)) u_dut1 (
        .clk(clk), .reset(rst_n), .addr(addr1), .wdata(wdata1), .rdata(rdata1),
        .req(req1), .wr(wr1), .rdy(rdy1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1), .oor(oor1)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] q4 [$];
    logic [63:0] q1 [$];
    logic [63:0] model4 [int];
    logic [63:0] model1 [int];
    logic [31:0] e_rd4 = '0;
    logic [31:0] e_wr4 = '0;
    logic        e_oor4 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One LAT=4 transaction, entered and left at a negedge in IDLE.
    task automatic xact4(input logic w, input logic [63:0] a, input logic [63:0] d, input string tag);
        int          k;
        logic        inr;
        logic [63:0] e;
        inr = ((a >> 10) == 64'd0);
        if (w) begin
            e = 64'd0;
            if (inr) model4[int'(a[9:0])] = d;
        end else begin
            e = (inr && model4.exists(int'(a[9:0]))) ? model4[int'(a[9:0])] : 64'd0;
        end
        q4.push_back(e);
        req4 = 1'b1; wr4 = w; addr4 = a; wdata4 = d;
        @(negedge clk);
        // Scramble inputs while the transaction is in flight.
        req4 = 1'b0; wr4 = ~w; addr4 = {$urandom, $urandom}; wdata4 = {$urandom, $urandom};
        k = 1;
        while (rdy4 !== 1'b1 && k < 12) begin
            chk({tag, "_rdata_not_rdy"}, rdata4, 64'd0);
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd4);
        e = (q4.size() > 0) ? q4.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
        chk({tag, "_rdata"}, rdata4, e);
        if (!inr) e_oor4 = 1'b1;
        if (w) e_wr4 = e_wr4 + 32'd1;
        else   e_rd4 = e_rd4 + 32'd1;
        @(negedge clk);
        chk({tag, "_gap_rdy"}, 64'(rdy4), 64'd0);
        chk({tag, "_gap_rdata"}, rdata4, 64'd0);
        chk({tag, "_wr_cnt"}, 64'(wr_cnt4), 64'(e_wr4));
        chk({tag, "_rd_cnt"}, 64'(rd_cnt4), 64'(e_rd4));
        chk({tag, "_oor"}, 64'(oor4), 64'(e_oor4));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        op_w [8];
        logic [63:0] op_a [8];
        logic [63:0] e;
        int          i;

        op_w = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        op_a = '{64'd10, 64'd11, 64'd12, 64'd10, 64'd11, 64'd12, 64'd10, 64'd11};

        rst_n = 1'b0;
        req4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        #2;
        chk("rst_rdy", 64'(rdy4), 64'd0);
        chk("rst_rdata", rdata4, 64'd0);
        chk("rst_rd_cnt", 64'(rd_cnt4), 64'd0);
        chk("rst_wr_cnt", 64'(wr_cnt4), 64'd0);
        chk("rst_oor", 64'(oor4), 64'd0);
        chk("rst_state", 64'(u_dut4.r_state), 64'(ST_IDLE));

        @(negedge clk);
        rst_n = 1'b1;
        // Basic write then read-after-write, back to back at minimum spacing.
        xact4(1'b1, 64'd5, 64'hDEAD_BEEF_0123_4567, "w5");
        xact4(1'b0, 64'd5, 64'h0, "r5");
        // Out-of-range handling.
        xact4(1'b1, 64'd0, 64'h1111_2222_3333_4444, "w0");
        xact4(1'b1, 64'h1_0000_0000, 64'hFFFF_0000_FFFF_0000, "w_oor");
        xact4(1'b0, 64'd0, 64'h0, "r0");
        xact4(1'b0, 64'h400, 64'h0, "r_oor");
        xact4(1'b0, 64'd5, 64'h0, "r5_again");

        // LAT=1 with req held high: 3 writes then 5 reads, one acceptance every 3rd edge.
        e = 64'hA000_0000_0000_0000 | op_a[0];
        model1[int'(op_a[0][9:0])] = e;
        q1.push_back(64'd0);
        req1 = 1'b1; wr1 = op_w[0]; addr1 = op_a[0]; wdata1 = e;
        i = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk($sformatf("l1_rdy_c%0d", k), 64'(rdy1), 64'((i < 8) && (k % 3 == 1)));
            if (rdy1 === 1'b1) begin
                e = (q1.size() > 0) ? q1.pop_front() : 64'hBAD1_BAD1_BAD1_BAD1;
                chk($sformatf("l1_rdata_op%0d", i), rdata1, e);
                i++;
                if (i < 8) begin
                    wr1 = op_w[i];
                    addr1 = op_a[i];
                    wdata1 = 64'hA000_0000_0000_0000 | op_a[i] | (64'(i) << 32);
                    if (op_w[i]) begin
                        model1[int'(op_a[i][9:0])] = wdata1;
                        q1.push_back(64'd0);
                    end else begin
                        q1.push_back(model1[int'(op_a[i][9:0])]);
                    end
                end else begin
                    req1 = 1'b0;
                end
            end else begin
                chk($sformatf("l1_rdata_idle_c%0d", k), rdata1, 64'd0);
            end
        end
        chk("l1_wr_cnt", 64'(wr_cnt1), 64'd3);
        chk("l1_rd_cnt", 64'(rd_cnt1), 64'd5);
        chk("l1_oor", 64'(oor1), 64'd0);

        // Reset in the second BUSY cycle of a read aborts it.
        xact4(1'b1, 64'd7, 64'hCAFE_F00D_5555_AAAA, "w7");
        req4 = 1'b1; wr4 = 1'b0; addr4 = 64'd7;
        @(negedge clk);
        req4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_state", 64'(u_dut4.r_state), 64'(ST_IDLE));
        chk("abort_rdy", 64'(rdy4), 64'd0);
        chk("abort_rd_cnt", 64'(rd_cnt4), 64'd0);
        chk("abort_wr_cnt", 64'(wr_cnt4), 64'd0);
        chk("abort_oor", 64'(oor4), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_rdy_rst_c%0d", k), 64'(rdy4), 64'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_rdy_post_c%0d", k), 64'(rdy4), 64'd0);
        end
        e_rd4 = '0; e_wr4 = '0; e_oor4 = 1'b0;
        xact4(1'b0, 64'd7, 64'h0, "r7_after_rst");

        // Write counter wraps from all-ones to zero.
        force u_dut4.r_wr_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_dut4.r_wr_cnt;
        chk("wrap_preload", 64'(wr_cnt4), 64'h0000_0000_FFFF_FFFF);
        e_wr4 = 32'hFFFF_FFFF;
        xact4(1'b1, 64'd9, 64'h0909_0909_0909_0909, "w_wrap");
        chk("wrap_zero", 64'(wr_cnt4), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
